// File: rtl/setup_sweep.sv
// setup_sweep: steps the setup reference code down from full scale until the
// synchronized comparator trips, then freezes the code and flags completion.
module setup_sweep #(
  parameter int WIDTH         = 10,
  parameter int STEP          = 1,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             i_cmp,
  output logic [WIDTH-1:0] i_ref_setup,
  output logic             completed,
  output logic             busy,
  output logic             fail
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_SAMPLE = 3'd2;
  localparam logic [2:0] ST_DONE   = 3'd3;
  localparam logic [2:0] ST_FAIL   = 3'd4;

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [WIDTH-1:0] CODE_FULL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CODE_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CODE_STEP = WIDTH'(STEP);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);

  logic [2:0]       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] code_r, code_s;
  logic             completed_r, completed_s;
  logic             busy_r, busy_s;
  logic             fail_r, fail_s;
  logic             cmp_meta_r, cmp_sync_r;
  logic             cmp_s;

  assign cmp_s       = cmp_sync_r;
  assign i_ref_setup = code_r;
  assign completed   = completed_r;
  assign busy        = busy_r;
  assign fail        = fail_r;

  // Next-state and next-output logic for the sweep sequencer
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    code_s      = code_r;
    completed_s = completed_r;
    busy_s      = busy_r;
    fail_s      = fail_r;
    if (abort) begin
      state_s     = ST_IDLE;
      cnt_s       = CNT_ZERO;
      code_s      = CODE_FULL;
      completed_s = 1'b0;
      busy_s      = 1'b0;
      fail_s      = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start) begin
            state_s     = ST_SETTLE;
            cnt_s       = CNT_ZERO;
            code_s      = CODE_FULL;
            completed_s = 1'b0;
            busy_s      = 1'b1;
            fail_s      = 1'b0;
          end else begin
            state_s = state_r;
          end
        end
        ST_SETTLE: begin
          if (cnt_r == CNT_LAST) begin
            cnt_s   = CNT_ZERO;
            state_s = ST_SAMPLE;
          end else begin
            cnt_s = cnt_r + CNT_ONE;
          end
        end
        ST_SAMPLE: begin
          // A trip at code 0 still counts as success
          if (cmp_s) begin
            state_s     = ST_DONE;
            completed_s = 1'b1;
            busy_s      = 1'b0;
          end else if (code_r == CODE_ZERO) begin
            state_s = ST_FAIL;
            fail_s  = 1'b1;
            busy_s  = 1'b0;
          end else begin
            code_s  = (code_r > CODE_STEP) ? (code_r - CODE_STEP) : CODE_ZERO;
            state_s = ST_SETTLE;
          end
        end
        default: begin
          state_s     = ST_IDLE;
          cnt_s       = CNT_ZERO;
          code_s      = CODE_FULL;
          completed_s = 1'b0;
          busy_s      = 1'b0;
          fail_s      = 1'b0;
        end
      endcase
    end
  end

  // State, output and comparator synchronizer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      code_r      <= CODE_FULL;
      completed_r <= 1'b0;
      busy_r      <= 1'b0;
      fail_r      <= 1'b0;
      cmp_meta_r  <= 1'b0;
      cmp_sync_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      code_r      <= code_s;
      completed_r <= completed_s;
      busy_r      <= busy_s;
      fail_r      <= fail_s;
      cmp_meta_r  <= i_cmp;
      cmp_sync_r  <= cmp_meta_r;
    end
  end

endmodule

// File: tb/tb_setup_sweep.sv
// Bench for setup_sweep: three WIDTH=4, SETTLE=2 instances (STEP 1, 3, 4) driven by
// a threshold comparator model; per-instance scoreboards check every finished sweep.
module tb_setup_sweep;

  localparam int NDUT = 3;
  localparam int HOLD = 3;
  localparam int STEP_OF [NDUT] = '{1, 3, 4};

  typedef struct {
    int        code;
    bit        done;
    bit        fail;
    int        cycles;
    bit [15:0] mask;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NDUT-1:0] start, abort, cmp_w, comp_w, busy_w, fail_w;
  logic [3:0]      ref_w [NDUT];
  int              thr   [NDUT];
  exp_t            sb_q  [NDUT][$];
  int              total = 0;
  int              bad   = 0;

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected outcome: list the codes the sweep visits, stop at the first one at or below threshold
  function automatic exp_t model(int step, int t);
    exp_t e;
    int   codes[$];
    int   c;
    bit   found;
    c = 15;
    codes.push_back(c);
    while (c != 0) begin
      c = (c > step) ? c - step : 0;
      codes.push_back(c);
    end
    e.mask = 16'h0000; e.done = 1'b0; e.fail = 1'b1; e.code = 0;
    e.cycles = HOLD * codes.size();
    found = 1'b0;
    for (int i = 0; i < codes.size(); i++) begin
      if (!found) begin
        e.mask[codes[i]] = 1'b1;
        if (codes[i] <= t) begin
          e.code = codes[i]; e.done = 1'b1; e.fail = 1'b0;
          e.cycles = HOLD * (i + 1);
          found = 1'b1;
        end
      end
    end
    return e;
  endfunction

  function automatic exp_t cancel_exp();
    exp_t e;
    e.code = 15; e.done = 1'b0; e.fail = 1'b0; e.cycles = 0; e.mask = 16'hFFFF;
    return e;
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    setup_sweep #(.WIDTH(4), .STEP(STEP_OF[g]), .SETTLE_CYCLES(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start[g]), .abort(abort[g]), .i_cmp(cmp_w[g]),
      .i_ref_setup(ref_w[g]), .completed(comp_w[g]), .busy(busy_w[g]), .fail(fail_w[g])
    );

    assign cmp_w[g] = (int'(ref_w[g]) <= thr[g]);

    initial begin : monitor
      int   run_len;
      bit   was_busy, trace_bad, both_bad;
      exp_t e;
      run_len = 0; was_busy = 1'b0; trace_bad = 1'b0; both_bad = 1'b0;
      forever begin
        @(negedge clk);
        if (busy_w[g] === 1'b1) begin
          run_len++;
          if (sb_q[g].size() > 0) begin
            e = sb_q[g][0];
            if (!e.mask[ref_w[g]]) trace_bad = 1'b1;
          end
        end
        if (comp_w[g] === 1'b1 && fail_w[g] === 1'b1) both_bad = 1'b1;
        if (was_busy && busy_w[g] === 1'b0) begin
          if (sb_q[g].size() == 0) begin
            total++; bad++;
            $display("FAIL dut%0d unexpected sweep end: code=%0d, no sweep was expected", g, ref_w[g]);
          end else begin
            e = sb_q[g].pop_front();
            chk($sformatf("dut%0d end code", g), ref_w[g], e.code);
            chk($sformatf("dut%0d completed", g), comp_w[g], e.done);
            chk($sformatf("dut%0d fail", g), fail_w[g], e.fail);
            if (e.cycles != 0) chk($sformatf("dut%0d sweep length", g), run_len, e.cycles);
            chk($sformatf("dut%0d stray code seen", g), trace_bad, 0);
            chk($sformatf("dut%0d completed and fail both set", g), both_bad, 0);
          end
          run_len = 0; trace_bad = 1'b0; both_bad = 1'b0;
        end
        was_busy = (busy_w[g] === 1'b1);
      end
    end
  end

  task automatic pulse_start(int k);
    @(negedge clk);
    start[k] = 1'b1;
    @(negedge clk);
    start[k] = 1'b0;
  endtask

  task automatic wait_idle(int k, int limit);
    int n = 0;
    while (sb_q[k].size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb_q[k].size() != 0) begin
      bad++;
      $display("FAIL dut%0d sweep timeout: still pending after %0d cycles, required end within %0d", k, n, limit);
      sb_q[k].delete();
    end
  endtask

  task automatic wait_code(int k, int code);
    int n = 0;
    while (ref_w[k] !== 4'(code) && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (ref_w[k] !== 4'(code)) begin
      bad++;
      $display("FAIL dut%0d wait for code: got %0d expected %0d", k, ref_w[k], code);
    end
  endtask

  task automatic sweep(int k, int t, bit hold, bit poke);
    exp_t e;
    thr[k] = t;
    repeat (3) @(negedge clk);
    e = model(STEP_OF[k], t);
    sb_q[k].push_back(e);
    pulse_start(k);
    if (poke) begin
      repeat (1 + $urandom_range(3)) @(negedge clk);
      if (busy_w[k] === 1'b1) begin
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
      end
    end
    wait_idle(k, 200);
    if (hold) begin
      repeat (20) @(negedge clk);
      chk($sformatf("dut%0d held code", k), ref_w[k], e.code);
      chk($sformatf("dut%0d held completed", k), comp_w[k], e.done);
      chk($sformatf("dut%0d held fail", k), fail_w[k], e.fail);
      chk($sformatf("dut%0d held busy", k), busy_w[k], 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = '0;
    abort = '0;
    for (int k = 0; k < NDUT; k++) thr[k] = -1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk($sformatf("dut%0d reset code", k), ref_w[k], 15);
      chk($sformatf("dut%0d reset completed", k), comp_w[k], 0);
      chk($sformatf("dut%0d reset busy", k), busy_w[k], 0);
      chk($sformatf("dut%0d reset fail", k), fail_w[k], 0);
    end
    rst_n = 1'b1;

    sweep(0, 7, 1'b1, 1'b0);   // nominal, completes at 7
    sweep(1, -1, 1'b1, 1'b0);  // STEP 3, no trip
    sweep(2, -1, 1'b1, 1'b0);  // STEP 4, saturates to 0
    sweep(0, 15, 1'b1, 1'b0);  // tripped at full scale

    // Abort at code 10, then start+abort together, then a clean re-sweep
    thr[0] = 7;
    sb_q[0].push_back(model(STEP_OF[0], 7));
    pulse_start(0);
    wait_code(0, 10);
    abort[0] = 1'b1;
    sb_q[0].delete();
    sb_q[0].push_back(cancel_exp());
    @(negedge clk);
    abort[0] = 1'b0;
    chk("abort busy", busy_w[0], 0);
    chk("abort code", ref_w[0], 15);
    chk("abort completed", comp_w[0], 0);
    start[0] = 1'b1;
    abort[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    abort[0] = 1'b0;
    @(negedge clk);
    chk("start+abort busy", busy_w[0], 0);
    chk("start+abort code", ref_w[0], 15);
    sweep(0, 7, 1'b1, 1'b1);

    // Asynchronous reset between edges while the code is 9
    thr[0] = 7;
    sb_q[0].push_back(model(STEP_OF[0], 7));
    pulse_start(0);
    wait_code(0, 9);
    #2;
    sb_q[0].delete();
    sb_q[0].push_back(cancel_exp());
    rst_n = 1'b0;
    #1;
    chk("async reset code", ref_w[0], 15);
    chk("async reset completed", comp_w[0], 0);
    chk("async reset busy", busy_w[0], 0);
    chk("async reset fail", fail_w[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post-reset busy", busy_w[0], 0);
    chk("post-reset code", ref_w[0], 15);
    sweep(0, 7, 1'b0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      int k, t;
      k = int'($urandom_range(NDUT - 1));
      t = int'($urandom_range(16)) - 1;
      sweep(k, t, 1'b0, 1'(($urandom_range(1))));
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/setup_sweep.md
Name: setup_sweep

Overview:
Generates the setup reference code and the completion flag consumed by the reference-select stage. On start, it presets the setup code to full scale. It then steps the code downward, allowing the analog path to settle at each step, until a synchronized comparator reports the target is reached. It then freezes the code and raises completed, which hands control of the reference over to the run-time value.

Parameters:
WIDTH, 10, width of the reference code
STEP, 1, decrement per sweep step (1 to 2**WIDTH-1)
SETTLE_CYCLES, 4, clocks the code is held before sampling the comparator (minimum 2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin or restart a sweep
abort  input  1  return to idle immediately
i_cmp  input  1  asynchronous comparator output; 1 = reference at or below target
i_ref_setup  output  WIDTH  setup reference code
completed  output  1  sweep finished successfully; code frozen
busy  output  1  sweep in progress
fail  output  1  code reached 0 without comparator trip

Behaviour:
- One clock domain: clk. Reset rst_n is asynchronous and active-low; all flops clear on assertion, and release is synchronous to clk.
- Reset values: i_ref_setup=2**WIDTH-1, completed=0, busy=0, fail=0, state=IDLE, settle counter=0, sync flops=0.
- i_cmp passes through a 2-flop synchronizer (cmp_s). The FSM uses only cmp_s.
- States: IDLE, SETTLE, SAMPLE, DONE, FAIL. All outputs are registered.
- IDLE:
  - When start=1 at an edge: i_ref_setup<=2**WIDTH-1, busy<=1, completed<=0, fail<=0, cnt<=0, go to SETTLE.
- SETTLE:
  - cnt increments each edge.
  - When cnt==SETTLE_CYCLES-1: cnt<=0, go to SAMPLE.
- SAMPLE (one cycle), at the edge:
  - If cmp_s=1: go to DONE, completed<=1, busy<=0, i_ref_setup held.
  - Else if i_ref_setup==0: go to FAIL, fail<=1, busy<=0.
  - Else: i_ref_setup<=(i_ref_setup>STEP) ? i_ref_setup-STEP : 0 (saturating, never wraps), then go to SETTLE.
- Each code is therefore held SETTLE_CYCLES+1 clocks.
- DONE and FAIL:
  - Outputs hold indefinitely.
  - start=1 restarts exactly as from IDLE.
- start while busy is ignored.
- abort=1 in any state: at the next edge go to IDLE, busy<=0, completed<=0, fail<=0, i_ref_setup<=2**WIDTH-1. abort has priority over start in the same cycle.
- Simultaneous cmp_s=1 and i_ref_setup==0 in SAMPLE: DONE takes priority over FAIL.
- If the comparator is already tripped at full scale, the sweep ends at the first SAMPLE with completed=1 and i_ref_setup=2**WIDTH-1.
- completed and fail are never both 1. busy is 1 only in SETTLE and SAMPLE.
- Reset asserted mid-sweep: outputs return to their reset values immediately, with no waiting for a clock edge.

Test Plan:
1. Reset, then nominal sweep (WIDTH=4, STEP=1, SETTLE=2, bench models i_cmp = (i_ref_setup<=7)). Pulse start at edge E0.
   -> Code is 15 from E0 and decrements every 3 clocks.
   -> At E27: completed=1, busy=0, i_ref_setup=7 held stable for 20 further cycles.
2. No trip (i_cmp=0, WIDTH=4, STEP=3, SETTLE=2).
   -> Codes 15, 12, 9, 6, 3, 0.
   -> fail=1 after the SAMPLE at code 0, completed=0, code stays 0 (no wrap to 15).
3. Saturation (WIDTH=4, STEP=4, i_cmp=0).
   -> Codes 15, 11, 7, 3, 0, then fail=1.
   -> No code other than these ever appears.
4. Immediate trip (i_cmp=1 held before start).
   -> completed=1 at the first SAMPLE (E0+3 for SETTLE=2), i_ref_setup=15.
5. Abort and restart: assert abort while the code is at 10 in the nominal setup.
   -> Next edge: busy=0, code=15, state IDLE.
   -> start and abort in the same cycle: stays IDLE.
   -> A later start: re-sweeps and completes at 7.
   -> start pulsed while busy: no effect on the sequence.
6. Async reset mid-sweep (drop rst_n between edges at code 9).
   -> Outputs read 15/0/0/0 before the next clk edge.
   -> After release, nothing moves until start is pulsed.
